// File: rtl/clkgen_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | clkgen_pkg : shared helpers for the clock-enable generator               |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package clkgen_pkg;

   function automatic int ch_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int ceil_half(input int n);
      return (n + 1) >>> 1;
   endfunction

   function automatic int div_norm(input int n);
      return (n == 0) ? 1 : n;
   endfunction

endpackage
`default_nettype wire

// File: rtl/clkgen_div_chan.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | clkgen_div_chan : one divider channel (counter, divisors, ce/sq/pend)    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module clkgen_div_chan
   import clkgen_pkg::*;
#(
   parameter int               DIV_W   = 8,
   parameter logic [DIV_W-1:0] DIV_RST = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_run,
   input  logic             i_sync,
   input  logic             i_we,
   input  logic [DIV_W-1:0] i_div,
   output logic             o_ce,
   output logic             o_sq,
   output logic             o_pend,
   output logic [DIV_W-1:0] o_div
);
   localparam logic [DIV_W-1:0] C_DIV_RST = DIV_W'(div_norm(int'(DIV_RST)));

   logic [DIV_W-1:0] r_cnt;
   logic [DIV_W-1:0] r_div;
   logic [DIV_W-1:0] r_pdiv;
   logic             r_pend;
   logic             r_ce;
   logic             r_sq;

   logic             w_last;
   logic             w_apply;
   logic [DIV_W-1:0] w_div_in;
   logic [DIV_W:0]   w_half;

   assign w_div_in = DIV_W'(div_norm(int'(i_div)));
   assign w_half   = (DIV_W+1)'(ceil_half(int'(r_div)));
   assign w_last   = (r_cnt == r_div - 1'b1);
   // Divisor changes only land on a period boundary, when idle, or on sync.
   assign w_apply  = ~i_run | w_last | i_sync;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt  <= '0;
         r_div  <= C_DIV_RST;
         r_pdiv <= '0;
         r_pend <= 1'b0;
         r_ce   <= 1'b0;
         r_sq   <= 1'b0;
      end else begin
         r_ce  <= i_run & w_last;
         r_sq  <= i_run & ({1'b0, r_cnt} < w_half);
         r_cnt <= w_apply ? '0 : r_cnt + 1'b1;
         if (i_we) begin
            if (w_apply) begin
               r_div  <= w_div_in;
               r_pend <= 1'b0;
            end else begin
               r_pdiv <= w_div_in;
               r_pend <= 1'b1;
            end
         end else if (w_apply && r_pend) begin
            r_div  <= r_pdiv;
            r_pend <= 1'b0;
         end
      end
   end

   assign o_ce   = r_ce;
   assign o_sq   = r_sq;
   assign o_pend = r_pend;
   assign o_div  = r_div;

endmodule
`default_nettype wire

// File: rtl/clkgen_div_ce.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | clkgen_div_ce : lock-qualified multi-channel clock-enable generator      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module clkgen_div_ce
   import clkgen_pkg::*;
#(
   parameter int                      NUM_CH   = 5,
   parameter int                      DIV_W    = 8,
   parameter logic [NUM_CH*DIV_W-1:0] DIV_INIT = {8'd16, 8'd8, 8'd4, 8'd2, 8'd1},
   parameter int                      LOCK_CYC = 1024
) (
   input  logic                      refclk,
   input  logic                      rst,
   input  logic                      pll_locked,
   input  logic                      sync_i,
   input  logic                      cfg_we,
   input  logic [ch_w(NUM_CH)-1:0]   cfg_ch,
   input  logic [DIV_W-1:0]          cfg_div,
   output logic                      ready_o,
   output logic [NUM_CH-1:0]         ce_o,
   output logic [NUM_CH-1:0]         sq_o,
   output logic [NUM_CH-1:0]         pend_o,
   output logic [NUM_CH*DIV_W-1:0]   div_o
);
   localparam int              CH_W       = ch_w(NUM_CH);
   localparam int              LC_W       = $clog2(LOCK_CYC + 1);
   localparam logic [LC_W-1:0] C_LOCK_MAX = LC_W'(LOCK_CYC);

   logic            r_lock_meta;
   logic            r_lock_sync;
   logic [LC_W-1:0] r_lock_cnt;
   logic            r_ready;

   logic [LC_W-1:0] w_lock_nxt;
   logic            w_run;
   logic            w_sync;

   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         r_lock_meta <= 1'b0;
         r_lock_sync <= 1'b0;
      end else begin
         r_lock_meta <= pll_locked;
         r_lock_sync <= r_lock_meta;
      end
   end

   assign w_lock_nxt = (r_lock_cnt == C_LOCK_MAX) ? r_lock_cnt : r_lock_cnt + 1'b1;

   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         r_lock_cnt <= '0;
         r_ready    <= 1'b0;
      end else if (!r_lock_sync) begin
         r_lock_cnt <= '0;
         r_ready    <= 1'b0;
      end else begin
         r_lock_cnt <= w_lock_nxt;
         r_ready    <= (w_lock_nxt == C_LOCK_MAX);
      end
   end

   // Gating with the synced lock stops the channels on the same edge ready drops.
   assign w_run  = r_ready & r_lock_sync;
   assign w_sync = sync_i & w_run;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      logic w_we;
      assign w_we = cfg_we & (cfg_ch == CH_W'(g));

      clkgen_div_chan #(
         .DIV_W   (DIV_W),
         .DIV_RST (DIV_INIT[g*DIV_W +: DIV_W])
      ) u_chan (
         .clk    (refclk),
         .rst    (rst),
         .i_run  (w_run),
         .i_sync (w_sync),
         .i_we   (w_we),
         .i_div  (cfg_div),
         .o_ce   (ce_o[g]),
         .o_sq   (sq_o[g]),
         .o_pend (pend_o[g]),
         .o_div  (div_o[g*DIV_W +: DIV_W])
      );
   end

   assign ready_o = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_clkgen_div_ce.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_clkgen_div_ce : self-checking bench with reference model              |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_clkgen_div_ce;
   localparam int          NCH      = 5;
   localparam int          LCK      = 8;
   localparam logic [39:0] INIT_DIV = 40'h10_08_04_02_01;

   logic        refclk = 1'b0;
   logic        rst = 1'b1;
   logic        pll_locked = 1'b0;
   logic        sync_i = 1'b0;
   logic        cfg_we = 1'b0;
   logic [2:0]  cfg_ch = '0;
   logic [7:0]  cfg_div = '0;
   logic        ready_o;
   logic [4:0]  ce_o, sq_o, pend_o;
   logic [39:0] div_o;

   clkgen_div_ce #(
      .NUM_CH(NCH), .DIV_W(8), .DIV_INIT(INIT_DIV), .LOCK_CYC(LCK)
   ) dut (
      .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .sync_i(sync_i),
      .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div), .ready_o(ready_o),
      .ce_o(ce_o), .sq_o(sq_o), .pend_o(pend_o), .div_o(div_o)
   );

   always #5 refclk = ~refclk;

   int n_cmp = 0;
   int n_err = 0;
   int t = 0;

   // Reference model: integer phase per channel, period arithmetic with modulo.
   bit m_s1, m_s2, m_ready;
   int m_lock;
   int m_n[NCH], m_ph[NCH], m_pv[NCH];
   bit m_pend[NCH], m_ce[NCH], m_sq[NCH];

   typedef struct {
      logic [2:0]  ch;
      logic [7:0]  div;
      logic [39:0] exp_div;
   } vec_t;
   vec_t tbl[7];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      logic [39:0] iv;
      iv = INIT_DIV;
      m_s1 = 0; m_s2 = 0; m_ready = 0; m_lock = 0;
      for (int i = 0; i < NCH; i++) begin
         m_n[i]    = (iv[i*8 +: 8] == 0) ? 1 : int'(iv[i*8 +: 8]);
         m_ph[i]   = 0;
         m_pv[i]   = 0;
         m_pend[i] = 0;
         m_ce[i]   = 0;
         m_sq[i]   = 0;
      end
   endtask

   task automatic model_step();
      bit run;
      if (rst) begin
         model_reset();
         return;
      end
      run = m_ready && m_s2;
      for (int i = 0; i < NCH; i++) begin
         bit wrap, app;
         int v;
         wrap    = run && (m_ph[i] == m_n[i] - 1);
         app     = !run || wrap || sync_i;
         m_ce[i] = wrap;
         m_sq[i] = run && (m_ph[i] < (m_n[i] + 1) / 2);
         m_ph[i] = (!run || sync_i) ? 0 : (m_ph[i] + 1) % m_n[i];
         v = (cfg_div == 0) ? 1 : int'(cfg_div);
         if (cfg_we && int'(cfg_ch) == i) begin
            if (app) begin m_n[i] = v; m_pend[i] = 0; end
            else     begin m_pv[i] = v; m_pend[i] = 1; end
         end else if (app && m_pend[i]) begin
            m_n[i] = m_pv[i];
            m_pend[i] = 0;
         end
      end
      if (!m_s2) begin
         m_lock = 0; m_ready = 0;
      end else begin
         if (m_lock < LCK) m_lock++;
         m_ready = (m_lock == LCK);
      end
      m_s2 = m_s1;
      m_s1 = pll_locked;
   endtask

   task automatic model_cmp();
      logic [4:0]  ece, esq, epd;
      logic [39:0] ediv;
      for (int i = 0; i < NCH; i++) begin
         ece[i] = m_ce[i];
         esq[i] = m_sq[i];
         epd[i] = m_pend[i];
         ediv[i*8 +: 8] = 8'(m_n[i]);
      end
      chk("model_ready", ready_o, m_ready);
      chk("model_ce", ce_o, ece);
      chk("model_sq", sq_o, esq);
      chk("model_pend", pend_o, epd);
      chk("model_div", div_o, ediv);
   endtask

   task automatic cyc();
      model_step();
      @(posedge refclk);
      @(negedge refclk);
      t++;
      model_cmp();
   endtask

   task automatic cycn(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic wr(input logic [2:0] ch, input logic [7:0] d);
      cfg_we = 1'b1; cfg_ch = ch; cfg_div = d;
      cyc();
      cfg_we = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{3'd7, 8'h33, 40'h10_08_04_02_01};
      tbl[1] = '{3'd1, 8'd0,  40'h10_08_04_01_01};
      tbl[2] = '{3'd2, 8'd5,  40'h10_08_05_01_01};
      tbl[3] = '{3'd5, 8'd9,  40'h10_08_05_01_01};
      tbl[4] = '{3'd4, 8'hFF, 40'hFF_08_05_01_01};
      tbl[5] = '{3'd0, 8'd3,  40'hFF_08_05_01_03};
      tbl[6] = '{3'd3, 8'd0,  40'hFF_01_05_01_03};

      model_reset();
      cycn(2);
      chk("rst_ready", ready_o, 0);
      chk("rst_ce", ce_o, 0);
      chk("rst_sq", sq_o, 0);
      chk("rst_pend", pend_o, 0);
      chk("rst_div", div_o, INIT_DIV);
      rst = 1'b0;

      // Unlocked writes apply at once; out-of-range channels are dropped.
      for (int i = 0; i < 7; i++) begin
         wr(tbl[i].ch, tbl[i].div);
         chk("tbl_div", div_o, tbl[i].exp_div);
         chk("tbl_pend", pend_o, 0);
      end
      #2 rst = 1'b1;
      #1;
      chk("arst_div", div_o, INIT_DIV);
      model_reset();
      cyc();
      rst = 1'b0;

      // Lock acquisition and cycle-k reference.
      pll_locked = 1'b1;
      cycn(9);
      chk("lock_not_yet", ready_o, 0);
      cyc();
      chk("lock_ready", ready_o, 1);
      chk("lock_ce_k", ce_o, 0);
      t = 0;
      for (int j = 1; j <= 32; j++) begin
         cyc();
         chk("ce0_const", ce_o[0], 1);
         chk("ce4_period", ce_o[4], (j % 16) == 0);
         chk("sq2_n4", sq_o[2], ((j - 1) % 4) < 2);
      end

      // Double write pends, sync applies the latest one.
      wr(3'd3, 8'd6);
      wr(3'd3, 8'd9);
      chk("dbl_pend", pend_o[3], 1);
      chk("dbl_div_old", div_o[31:24], 8);
      sync_i = 1'b1;
      cyc();
      sync_i = 1'b0;
      t = 0;
      chk("sync_pend", pend_o[3], 0);
      chk("sync_div", div_o[31:24], 9);

      // Duty change on ch2 from 4 to 5.
      wr(3'd2, 8'd5);
      chk("n5_pend", pend_o[2], 1);
      for (int n = 0; n < 10 && pend_o[2]; n++) cyc();
      chk("n5_pend_clr", pend_o[2], 0);
      chk("n5_div", div_o[23:16], 5);
      for (int j = 1; j <= 10; j++) begin
         cyc();
         chk("sq2_n5", sq_o[2], ((j - 1) % 5) < 3);
      end

      // Glitch-free switch 16 -> 3 on ch4 written at cnt=5.
      for (int n = 0; n < 16 && (t % 16) != 5; n++) cyc();
      wr(3'd4, 8'd3);
      chk("sw_pend0", pend_o[4], 1);
      for (int j = 1; j <= 16; j++) begin
         cyc();
         if (j < 10) chk("sw_pend", pend_o[4], 1);
         else        chk("sw_pend_clr", pend_o[4], 0);
         chk("sw_ce4", ce_o[4], (j >= 10) && ((j - 10) % 3 == 0));
      end

      // Zero divisor on ch1 -> N=1, continuous enable.
      wr(3'd1, 8'd0);
      for (int n = 0; n < 4 && pend_o[1]; n++) cyc();
      chk("z_div", div_o[15:8], 1);
      for (int j = 0; j < 4; j++) begin
         chk("z_ce1", ce_o[1], 1);
         cyc();
      end

      // Randomised traffic with occasional lock loss and sync.
      for (int j = 0; j < 400; j++) begin
         cfg_we  = ($urandom_range(0, 9) < 3);
         cfg_ch  = 3'($urandom_range(0, 7));
         cfg_div = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                               : 8'($urandom_range(0, 12));
         sync_i  = ($urandom_range(0, 99) < 3);
         if (pll_locked && $urandom_range(0, 99) == 0) pll_locked = 1'b0;
         else if (!pll_locked && $urandom_range(0, 9) < 2) pll_locked = 1'b1;
         cyc();
      end
      cfg_we = 1'b0; sync_i = 1'b0; pll_locked = 1'b1;
      cycn(20);
      chk("pre_loss_ready", ready_o, 1);

      // Lock loss mid-period.
      pll_locked = 1'b0;
      cycn(3);
      chk("loss_ready", ready_o, 0);
      chk("loss_ce", ce_o, 0);
      chk("loss_sq", sq_o, 0);
      wr(3'd4, 8'd50);
      chk("idle_wr_div", div_o[39:32], 50);
      chk("idle_wr_pend", pend_o[4], 0);
      pll_locked = 1'b1;
      cycn(9);
      chk("relock_not_yet", ready_o, 0);
      cyc();
      chk("relock_ready", ready_o, 1);
      wr(3'd4, 8'd7);
      chk("pre_rst_pend", pend_o[4], 1);
      cycn(3);

      // Asynchronous reset mid-run.
      #2 rst = 1'b1;
      #1;
      chk("arst2_ready", ready_o, 0);
      chk("arst2_ce", ce_o, 0);
      chk("arst2_sq", sq_o, 0);
      chk("arst2_pend", pend_o, 0);
      chk("arst2_div", div_o, INIT_DIV);
      model_reset();
      cyc();
      rst = 1'b0;
      cycn(3);
      chk("post_rst_pend", pend_o, 0);
      chk("post_rst_div", div_o, INIT_DIV);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
